// File: rtl/fpu_disp_pkg.sv
// Shared types and constants for the FPU operation dispatcher.
// Holds the FSM state type, op-word field bounds, error bit indices and the rm check.
package fpu_disp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam int OP_SEL_LSB = 2;
   localparam int OP_SEL_MSB = 12;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam int          FLAG_NV   = 4;

   localparam int ERR_ILLEGAL = 0;
   localparam int ERR_OVERRUN = 1;
   localparam int ERR_TIMEOUT = 2;

   // Rounding modes 101, 110 and 111 are reserved.
   function automatic logic rm_reserved(input logic [2:0] rm);
      return rm[2] & (rm[1] | rm[0]);
   endfunction

endpackage

// File: rtl/fpu_disp_timer.sv
// Timeout counter for the dispatcher: clear, count while enabled, flag expiry.
// Ports: clk, rst (async high), i_clr, i_en, o_expire (high on the last allowed cycle).
module fpu_disp_timer #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TMR_W          = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + TMR_W'(1);
      end
   end

   // Expire in the cycle whose increment would reach TIMEOUT_CYCLES,
   // so exactly TIMEOUT_CYCLES enabled cycles elapse before DONE.
   assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/fpu_op_dispatcher.sv
// Issues one snapshotted FPU operation per OPERATION write and returns the result.
// Ports: op_start/op_valids/opA-C/frm request in, exu_* handshake, fpu_valids/result out, busy, err.
module fpu_op_dispatcher #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TMR_W          = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_start,
   input  logic [12:0] op_valids,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic [31:0] opC,
   input  logic [2:0]  frm,
   input  logic        err_clr,
   output logic        exu_valid,
   input  logic        exu_ready,
   output logic [12:0] exu_op,
   output logic [31:0] exu_a,
   output logic [31:0] exu_b,
   output logic [31:0] exu_c,
   output logic [2:0]  exu_rm,
   input  logic        exu_done,
   input  logic [31:0] exu_result,
   input  logic [4:0]  exu_flags,
   output logic [12:0] fpu_valids,
   output logic [31:0] fpu_result,
   output logic [4:0]  exceptions,
   output logic        busy,
   output logic [2:0]  err
);

   import fpu_disp_pkg::*;

   state_t      r_state;
   state_t      w_next;
   logic [12:0] r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_c;
   logic [2:0]  r_rm;
   logic [31:0] r_result;
   logic [4:0]  r_flags;
   logic [2:0]  r_err;

   logic        w_legal;
   logic        w_snap;
   logic        w_cap;
   logic        w_tmo;
   logic        w_expire;
   logic        w_tmr_en;
   logic        w_tmr_clr;
   logic [2:0]  w_err_set;

   // Sub-op bits [1:0] are not checked; they travel with the op word.
   assign w_legal = $onehot(op_valids[OP_SEL_MSB:OP_SEL_LSB])
                 && !rm_reserved(frm);

   assign w_tmr_en  = (r_state == ISSUE) || (r_state == WAIT);
   assign w_tmr_clr = (r_state == IDLE);

   fpu_disp_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TMR_W          (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_tmr_clr),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next    = r_state;
      w_snap    = 1'b0;
      w_cap     = 1'b0;
      w_tmo     = 1'b0;
      w_err_set = '0;
      unique case (r_state)
         IDLE: begin
            if (op_start) begin
               if (w_legal) begin
                  w_snap = 1'b1;
                  w_next = ISSUE;
               end else begin
                  w_err_set[ERR_ILLEGAL] = 1'b1;
               end
            end
         end
         ISSUE: begin
            w_err_set[ERR_OVERRUN] = op_start;
            // A completion in the handshake cycle beats the timeout.
            if (exu_ready && exu_done) begin
               w_cap  = 1'b1;
               w_next = DONE;
            end else if (w_expire) begin
               w_tmo  = 1'b1;
               w_next = DONE;
            end else if (exu_ready) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            w_err_set[ERR_OVERRUN] = op_start;
            if (exu_done) begin
               w_cap  = 1'b1;
               w_next = DONE;
            end else if (w_expire) begin
               w_tmo  = 1'b1;
               w_next = DONE;
            end
         end
         DONE: begin
            w_err_set[ERR_OVERRUN] = op_start;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      w_err_set[ERR_TIMEOUT] = w_tmo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op <= '0;
         r_a  <= '0;
         r_b  <= '0;
         r_c  <= '0;
         r_rm <= '0;
      end else if (w_snap) begin
         r_op <= op_valids;
         r_a  <= opA;
         r_b  <= opB;
         r_c  <= opC;
         r_rm <= frm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_flags  <= '0;
      end else if (w_cap) begin
         r_result <= exu_result;
         r_flags  <= exu_flags;
      end else if (w_tmo) begin
         r_result <= CANON_NAN;
         r_flags  <= 5'(1 << FLAG_NV);
      end
   end

   // Clear first, then OR in new events so a set wins over err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= '0;
      end else begin
         r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
      end
   end

   assign exu_valid  = (r_state == ISSUE);
   assign exu_op     = r_op;
   assign exu_a      = r_a;
   assign exu_b      = r_b;
   assign exu_c      = r_c;
   assign exu_rm     = r_rm;
   assign fpu_valids = (r_state == DONE) ? r_op : 13'h0000;
   assign fpu_result = r_result;
   assign exceptions = r_flags;
   assign busy       = (r_state != IDLE);
   assign err        = r_err;

endmodule

// File: tb/tb_fpu_op_dispatcher.sv
// Self-checking bench for fpu_op_dispatcher with a short timeout.
// Table vectors, hand sequences for overrun/reset, then random ops vs a reference model.
module tb_fpu_op_dispatcher;

   localparam int T   = 8;
   localparam int WIN = T + 4;

   logic        clk;
   logic        rst;
   logic        op_start;
   logic [12:0] op_valids;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] opC;
   logic [2:0]  frm;
   logic        err_clr;
   logic        exu_valid;
   logic        exu_ready;
   logic [12:0] exu_op;
   logic [31:0] exu_a;
   logic [31:0] exu_b;
   logic [31:0] exu_c;
   logic [2:0]  exu_rm;
   logic        exu_done;
   logic [31:0] exu_result;
   logic [4:0]  exu_flags;
   logic [12:0] fpu_valids;
   logic [31:0] fpu_result;
   logic [4:0]  exceptions;
   logic        busy;
   logic [2:0]  err;

   fpu_op_dispatcher #(
      .TIMEOUT_CYCLES (T),
      .TMR_W          (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .op_start   (op_start),
      .op_valids  (op_valids),
      .opA        (opA),
      .opB        (opB),
      .opC        (opC),
      .frm        (frm),
      .err_clr    (err_clr),
      .exu_valid  (exu_valid),
      .exu_ready  (exu_ready),
      .exu_op     (exu_op),
      .exu_a      (exu_a),
      .exu_b      (exu_b),
      .exu_c      (exu_c),
      .exu_rm     (exu_rm),
      .exu_done   (exu_done),
      .exu_result (exu_result),
      .exu_flags  (exu_flags),
      .fpu_valids (fpu_valids),
      .fpu_result (fpu_result),
      .exceptions (exceptions),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // op..clr are stimulus; ek (0 = no pulse), eres, efl, env, eerr are expectations.
   typedef struct {
      logic [12:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [2:0]  rm;
      int          r;
      int          d;
      logic [31:0] res;
      logic [4:0]  fl;
      bit          clr;
      int          ek;
      logic [31:0] eres;
      logic [4:0]  efl;
      int          env;
      logic [2:0]  eerr;
   } vec_t;

   vec_t tbl[8];
   logic [2:0] m_err;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Ready pulses r cycles after ISSUE entry; done pulses d cycles after that.
   task automatic run_txn(input vec_t v, output int np, output int pk,
                          output logic [12:0] pv, output logic [31:0] pr,
                          output logic [4:0] pf, output bit st,
                          output int nv, output logic bz,
                          output logic [2:0] er);
      np = 0; pk = 0; pv = '0; pr = '0; pf = '0; st = 1'b1; nv = 0;
      if (v.clr) begin
         @(posedge clk); #1 err_clr = 1'b1;
         @(posedge clk); #1 err_clr = 1'b0;
      end
      @(posedge clk); #1;
      op_start  = 1'b1;
      op_valids = v.op;
      opA = v.a; opB = v.b; opC = v.c; frm = v.rm;
      exu_ready = 1'b0; exu_done = 1'b0;
      for (int k = 1; k <= WIN; k++) begin
         @(posedge clk); #1;
         op_start  = 1'b0;
         op_valids = 13'($urandom);
         opA = $urandom; opB = $urandom; opC = $urandom;
         frm = 3'($urandom);
         exu_ready = (k == 1 + v.r);
         exu_done  = (k == 1 + v.r + v.d);
         exu_result = exu_done ? v.res : $urandom;
         exu_flags  = exu_done ? v.fl : 5'($urandom);
         @(negedge clk);
         if (exu_valid) begin
            nv++;
            if (exu_op !== v.op || exu_a !== v.a || exu_b !== v.b ||
                exu_c !== v.c || exu_rm !== v.rm) st = 1'b0;
         end
         if (fpu_valids != 13'h0) begin
            np++; pk = k; pv = fpu_valids; pr = fpu_result; pf = exceptions;
         end
      end
      exu_ready = 1'b0; exu_done = 1'b0;
      bz = busy; er = err;
   endtask

   task automatic check_txn(input string nm, input vec_t v);
      int np, pk, nv;
      logic [12:0] pv;
      logic [31:0] pr;
      logic [4:0]  pf;
      bit st;
      logic bz;
      logic [2:0] er;
      run_txn(v, np, pk, pv, pr, pf, st, nv, bz, er);
      chk({nm, " pulses"}, np, (v.ek != 0) ? 1 : 0);
      if (v.ek != 0) begin
         chk({nm, " pulse_cycle"}, pk, v.ek);
         chk({nm, " fpu_valids"}, 32'(pv), 32'(v.op));
         chk({nm, " fpu_result"}, pr, v.eres);
         chk({nm, " exceptions"}, 32'(pf), 32'(v.efl));
      end
      chk({nm, " valid_cycles"}, nv, v.env);
      chk({nm, " snapshot_stable"}, 32'(st), 32'd1);
      chk({nm, " busy_after"}, 32'(bz), 32'd0);
      chk({nm, " err"}, 32'(er), 32'(v.eerr));
   endtask

   // Reference: legality by counting select bits; timing from cycle arithmetic.
   task automatic model(inout vec_t v);
      int ones;
      int done_k;
      ones = 0;
      for (int i = 2; i <= 12; i++) ones += int'(v.op[i]);
      if (v.clr) m_err = 3'b000;
      v.ek = 0; v.eres = '0; v.efl = '0; v.env = 0;
      if (ones != 1 || v.rm >= 3'd5) begin
         m_err[0] = 1'b1;
      end else begin
         v.env  = (v.r + 1 <= T) ? v.r + 1 : T;
         done_k = 1 + v.r + v.d;
         if (done_k <= T) begin
            v.ek = done_k + 1; v.eres = v.res; v.efl = v.fl;
         end else begin
            v.ek = T + 1; v.eres = 32'h7FC0_0000; v.efl = 5'b10000;
            m_err[2] = 1'b1;
         end
      end
      v.eerr = m_err;
   endtask

   initial begin
      int np, pk;
      logic [12:0] pv;
      vec_t v;

      tbl[0] = '{13'h0004, 32'h3F80_0000, 32'h4000_0000, 32'h0, 3'd0,
                 0, 3, 32'h4040_0000, 5'h00, 1'b0,
                 5, 32'h4040_0000, 5'h00, 1, 3'b000};
      tbl[1] = '{13'h000C, 32'h1, 32'h2, 32'h3, 3'd0,
                 0, 0, 32'h0, 5'h00, 1'b0,
                 0, 32'h0, 5'h00, 0, 3'b001};
      tbl[2] = '{13'h0010, 32'h4, 32'h5, 32'h6, 3'b110,
                 0, 0, 32'h0, 5'h00, 1'b1,
                 0, 32'h0, 5'h00, 0, 3'b001};
      tbl[3] = '{13'h1003, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                 3'b100, 5, 0, 32'h1234_5678, 5'h01, 1'b1,
                 7, 32'h1234_5678, 5'h01, 6, 3'b000};
      tbl[4] = '{13'h0800, 32'h7, 32'h8, 32'h9, 3'b001,
                 0, 9, 32'h0, 5'h00, 1'b0,
                 9, 32'h7FC0_0000, 5'h10, 1, 3'b100};
      tbl[5] = '{13'h0080, 32'hA, 32'hB, 32'hC, 3'b011,
                 3, 4, 32'hAAAA_5555, 5'h06, 1'b1,
                 9, 32'hAAAA_5555, 5'h06, 4, 3'b000};
      tbl[6] = '{13'h0200, 32'hD, 32'hE, 32'hF, 3'b010,
                 12, 0, 32'h0, 5'h00, 1'b0,
                 9, 32'h7FC0_0000, 5'h10, 8, 3'b100};
      tbl[7] = '{13'h0102, 32'h10, 32'h20, 32'h30, 3'b000,
                 0, 0, 32'h0BAD_F00D, 5'h1F, 1'b1,
                 2, 32'h0BAD_F00D, 5'h1F, 1, 3'b000};

      rst = 1'b1; op_start = 1'b0; op_valids = '0;
      opA = '0; opB = '0; opC = '0; frm = '0; err_clr = 1'b0;
      exu_ready = 1'b0; exu_done = 1'b0; exu_result = '0; exu_flags = '0;
      #12;
      chk("rst exu_valid", 32'(exu_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst fpu_valids", 32'(fpu_valids), 32'd0);
      chk("rst fpu_result", fpu_result, 32'd0);
      chk("rst err", 32'(err), 32'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 8; i++) check_txn($sformatf("tbl%0d", i), tbl[i]);

      // Overrun: second op_start while the first op is in WAIT.
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      op_start = 1'b1; op_valids = 13'h0020; opA = 32'hCAFE_0001;
      opB = 32'h0; opC = 32'h0; frm = 3'd0;
      np = 0; pk = 0; pv = '0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         op_start = (k == 2);
         if (k == 2) begin
            op_valids = 13'h0040; opA = 32'hDEAD_0000;
         end
         exu_ready = (k == 1);
         exu_done  = (k == 4);
         exu_result = 32'h5A5A_5A5A; exu_flags = 5'h01;
         @(negedge clk);
         if (fpu_valids != 13'h0) begin
            np++; pk = k; pv = fpu_valids;
         end
      end
      exu_ready = 1'b0; exu_done = 1'b0;
      chk("ovr pulses", np, 1);
      chk("ovr pulse_cycle", pk, 5);
      chk("ovr fpu_valids", 32'(pv), 32'h0020);
      chk("ovr exu_a", exu_a, 32'hCAFE_0001);
      chk("ovr exu_op", 32'(exu_op), 32'h0020);
      chk("ovr err", 32'(err), 32'b010);

      // err_clr in the same cycle as an illegal request: the set wins.
      @(posedge clk); #1;
      err_clr = 1'b1; op_start = 1'b1; op_valids = 13'h000C;
      @(posedge clk); #1;
      err_clr = 1'b0; op_start = 1'b0;
      @(negedge clk);
      chk("clr_vs_set err", 32'(err), 32'b001);
      chk("clr_vs_set busy", 32'(busy), 32'd0);

      // Async reset while in WAIT, between clock edges.
      @(posedge clk); #1;
      op_start = 1'b1; op_valids = 13'h0400; frm = 3'd0; opA = 32'h77;
      @(posedge clk); #1;
      op_start = 1'b0; exu_ready = 1'b1;
      @(posedge clk); #1;
      exu_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst exu_op", 32'(exu_op), 32'd0);
      chk("arst exu_a", exu_a, 32'd0);
      chk("arst fpu_result", fpu_result, 32'd0);
      chk("arst exceptions", 32'(exceptions), 32'd0);
      chk("arst err", 32'(err), 32'd0);
      #1 rst = 1'b0;
      np = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         exu_done = (k == 1);
         @(negedge clk);
         if (fpu_valids != 13'h0) np++;
      end
      exu_done = 1'b0;
      chk("arst no_pulse", np, 0);
      chk("arst busy_after", 32'(busy), 32'd0);
      check_txn("post_rst", tbl[0]);

      // Random ops against the reference model.
      m_err = 3'b000;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0)
            v.op = (13'd1 << (2 + $urandom_range(0, 10)))
                 | 13'($urandom_range(0, 3));
         else
            v.op = 13'($urandom);
         v.a = $urandom; v.b = $urandom; v.c = $urandom;
         v.rm = 3'($urandom_range(0, 7));
         v.r = $urandom_range(0, 9);
         v.d = $urandom_range(0, 9);
         v.res = $urandom;
         v.fl = 5'($urandom);
         v.clr = (i == 0) || ($urandom_range(0, 3) == 0);
         model(v);
         check_txn($sformatf("rnd%0d", i), v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_op_dispatcher.md
Name: fpu_op_dispatcher

Overview:
- Sits directly downstream of the FPU register block.
- On a software write to OPERATION, it snapshots operands, rounding mode and the one-hot op word, and issues one operation to the FPU execution unit with a valid/ready handshake.
- It waits for completion, or times out, then returns a one-cycle fpu_valids pulse with fpu_result and exceptions, which the register block consumes to load RESULT, OPERATION_COMPLETED, fflags and the interrupt.

Parameters:
TIMEOUT_CYCLES, 256, cycles allowed in ISSUE+WAIT before forced completion; minimum 4.
TMR_W, 9, timeout counter width; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  single clock for the block
rst  input  1  asynchronous, active-high reset
op_start  input  1  one-cycle pulse when software writes OPERATION
op_valids  input  13  [12:2] one-hot op select, [1:0] sub-op field
opA  input  32  operand A
opB  input  32  operand B
opC  input  32  operand C
frm  input  3  rounding mode
err_clr  input  1  clears sticky error bits
exu_valid  output  1  issue request to execution unit
exu_ready  input  1  execution unit accepts issue
exu_op  output  13  snapshotted op word
exu_a  output  32  snapshotted operand A
exu_b  output  32  snapshotted operand B
exu_c  output  32  snapshotted operand C
exu_rm  output  3  snapshotted rounding mode
exu_done  input  1  one-cycle completion strobe
exu_result  input  32  result, valid with exu_done
exu_flags  input  5  {NV,DZ,OF,UF,NX}, valid with exu_done
fpu_valids  output  13  one-cycle completion pulse carrying the snapshotted op word
fpu_result  output  32  result, held until the next completion
exceptions  output  5  flags, held until the next completion
busy  output  1  high in ISSUE, WAIT and DONE
err  output  3  sticky {timeout, overrun, illegal}

Behaviour:
- Reset (async, immediate on rst high): state IDLE; every output and snapshot register is 0.
- States:
  - IDLE: on op_start with a legal request, snapshot op_valids, opA/B/C and frm -> ISSUE. Illegal request -> stay in IDLE, set err[0].
  - ISSUE: exu_valid=1, outputs stable. exu_valid&&exu_ready -> WAIT. If exu_done is also high in the same cycle, capture it and go straight to DONE.
  - WAIT: exu_done -> capture exu_result/exu_flags -> DONE.
  - DONE: fpu_valids = snapshotted op word for exactly this one cycle -> IDLE.
- Legal request means all three hold:
  - popcount(op_valids[12:2]) == 1;
  - frm not in {101,110,111};
  - bits [1:0] are free and pass through unchanged.
- Latency: op_start at cycle N -> exu_valid from N+1. With exu_ready at N+1 and exu_done at cycle M, fpu_valids pulses at M+1. Minimum op_start-to-fpu_valids is 2 cycles (ready and done in the same cycle).
- exu_valid never drops before the handshake. exu_op/a/b/c/rm are constant from ISSUE entry until the next snapshot.
- Timeout:
  - Counter clears on ISSUE entry and increments each cycle in ISSUE or WAIT.
  - On reaching TIMEOUT_CYCLES: fpu_result=32'h7FC0_0000, exceptions=5'b10000 (NV), set err[2] -> DONE.
  - exu_done arriving in that same cycle takes priority and is a normal completion.
- op_start while busy: ignored, set err[1]; snapshots are not disturbed.
- exu_done in IDLE/ISSUE(without handshake)/DONE: ignored.
- err_clr: clears all err bits. If it coincides with a set event, the set wins.
- fpu_result/exceptions update only on entry to DONE; outside the pulse they hold their last values.
- Reset mid-operation: returns to IDLE; no fpu_valids pulse; in-flight exu_done after reset is ignored.

Decomposition:
- Package fpu_disp_pkg holds:
  - state enum {IDLE,ISSUE,WAIT,DONE};
  - OP_SEL_LSB=2, OP_SEL_MSB=12;
  - CANON_NAN=32'h7FC0_0000;
  - FLAG_NV=4;
  - ERR_ILLEGAL=0, ERR_OVERRUN=1, ERR_TIMEOUT=2;
  - reserved-rm check function.
- One sub-module, fpu_disp_timer: clear/enable/expire counter parameterised by TIMEOUT_CYCLES and TMR_W.
- The FSM, snapshot registers and legality check stay in the top module.

Test Plan:
- Basic add: op_valids=13'h0004, opA=3F80_0000, opB=4000_0000, frm=0, exu_ready same cycle, exu_done 3 cycles later with 4040_0000/flags 0 -> fpu_valids=0004 for 1 cycle, fpu_result=4040_0000, exceptions=0, busy low after.
- Backpressure: exu_ready held low 5 cycles -> exu_valid and exu_a/b/c stable all 5 cycles. Change opA in that window -> exu_a unchanged.
- Illegal: op_valids=13'h000C (two bits), then frm=3'b110 with a legal op -> no exu_valid, err=3'b001 each time; err_clr -> err=0.
- Overrun: second op_start during WAIT -> err[1]=1, first op completes with the original snapshot, only one fpu_valids pulse.
- Timeout: TIMEOUT_CYCLES=8, never assert exu_done -> pulse 9 cycles after ISSUE entry (8 counted cycles, then DONE), fpu_result=7FC0_0000, exceptions=10000, err[2]=1. A late exu_done is then ignored.
- Async reset asserted in WAIT between clock edges -> outputs 0 immediately; no pulse after release; next legal op completes normally.
